// File: rtl/vericade_pkg.sv
// Shared Vericade definitions: button count, button indices and the
// per-button channel state encoding.
package vericade_pkg;

    localparam int NUM_BTN    = 5;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } btn_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce counter, press/repeat FSM and
// the repeat interval counter.
module button_channel
    import vericade_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    btn_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             accept;
    logic             stable;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= RELEASED;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    always_comb begin
        db_cnt_d  = '0;
        level_d   = level_q;
        pulse_d   = 1'b0;
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        accept    = 1'b0;
        stable    = (sync2_q == level_q);

        if (!stable) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Repeat counting pauses while a level change is pending, so a
        // release in progress never produces a stray repeat pulse.
        case (state_q)
            RELEASED: begin
                if (accept) begin
                    state_d   = HELD;
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            HELD: begin
                if (accept) begin
                    state_d   = RELEASED;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN && stable) begin
                    if (rpt_cnt_q == DELAY_LAST) begin
                        state_d   = REPEATING;
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            REPEATING: begin
                if (accept) begin
                    state_d   = RELEASED;
                    rpt_cnt_d = '0;
                end else if (stable) begin
                    if (rpt_cnt_q == RATE_LAST) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = RELEASED;
                rpt_cnt_d = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels between the board pins and the
// game-select mux; produces debounced levels and press/repeat pulses.
module button_conditioner
    import vericade_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_RATE     = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("REPEAT_RATE must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_MASK[i]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk_i  (clk),
            .rst_i  (rst),
            .raw_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .pulse_o(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner: per-cycle stimulus/expectation
// records feed a scoreboard queue that is checked one cycle later.
module tb_button_conditioner;

    localparam int          DB  = 4;
    localparam int          RD  = 10;
    localparam int          RR  = 3;
    localparam logic [4:0]  RM  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = 5'b00000;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic [4:0] level;
        logic [4:0] pulse;
    } step_t;

    step_t      tbl[$];
    logic [9:0] exp_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_MASK    (RM),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [9:0] exp);
        n_cmp++;
        if ({btn_level, btn_pulse} !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got level=%b pulse=%b, expected level=%b pulse=%b",
                     name, idx, btn_level, btn_pulse, exp[9:5], exp[4:0]);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] raw, input logic [4:0] lvl,
                       input logic [4:0] pls);
        step_t s;
        s.rst   = r;
        s.raw   = raw;
        s.level = lvl;
        s.pulse = pls;
        tbl.push_back(s);
    endtask

    // Step k is driven before edge k and its expectation is checked after it.
    task automatic run_table(input string name);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            if (k > 0) check(name, k - 1, exp_q.pop_front());
            rst     = tbl[k].rst;
            btn_raw = tbl[k].raw;
            exp_q.push_back({tbl[k].level, tbl[k].pulse});
        end
        @(negedge clk);
        check(name, tbl.size() - 1, exp_q.pop_front());
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        btn_raw = 5'b00000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bounce_pat[6] = '{1, 0, 1, 1, 0, 1};
        logic b;

        repeat (3) @(negedge clk);
        check("reset_state", 0, 10'b0);

        // Clean press on a non-repeating button; held long past REPEAT_DELAY.
        for (int k = 0; k < 20; k++)
            add(1'b0, 5'b00100, (k >= 5) ? 5'b00100 : 5'b00000,
                (k == 5) ? 5'b00100 : 5'b00000);
        run_table("clean_press");
        do_reset();

        // Bouncing press: only the final stable run qualifies.
        for (int k = 0; k < 16; k++) begin
            b = (k < 6) ? (bounce_pat[k] != 0) : 1'b1;
            add(1'b0, {3'b000, b, 1'b0}, (k >= 10) ? 5'b00010 : 5'b00000,
                (k == 10) ? 5'b00010 : 5'b00000);
        end
        run_table("bounce");
        do_reset();

        // Auto-repeat on button 0, released before edge 22.
        for (int k = 0; k < 33; k++)
            add(1'b0, (k <= 21) ? 5'b00001 : 5'b00000,
                (k >= 5 && k <= 26) ? 5'b00001 : 5'b00000,
                (k inside {5, 15, 18, 21}) ? 5'b00001 : 5'b00000);
        run_table("auto_repeat");
        do_reset();

        // Four buttons pressed together.
        for (int k = 0; k < 16; k++)
            add(1'b0, 5'b11110, (k >= 5) ? 5'b11110 : 5'b00000,
                (k == 5) ? 5'b11110 : 5'b00000);
        run_table("simultaneous");
        do_reset();

        // Held button with a low excursion one cycle shorter than the debounce window.
        for (int k = 0; k < 19; k++)
            add(1'b0, (k >= 8 && k <= 10) ? 5'b00000 : 5'b00100,
                (k >= 5) ? 5'b00100 : 5'b00000,
                (k == 5) ? 5'b00100 : 5'b00000);
        run_table("short_glitch");
        do_reset();

        // Reset pulse at edge 3 interrupts debounce; press re-qualifies from edge 4.
        for (int k = 0; k < 15; k++)
            add((k == 3), 5'b01000, (k >= 9) ? 5'b01000 : 5'b00000,
                (k == 9) ? 5'b01000 : 5'b00000);
        run_table("reset_mid_debounce");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
